// File: rtl/mux_rr_reg.sv
// mux_rr_reg: round-robin arbitrated valid/ready mux into one registered output; MUX_RR_FORCE_SEL_EN adds a forced channel select
module mux_rr_reg #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
`ifdef MUX_RR_FORCE_SEL_EN
  input  logic                      FORCE_EN,
  input  logic [SEL_W-1:0]          FORCE_SEL,
`endif
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic [SEL_W-1:0]          OUT_SEL,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY
);
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_gnt;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] din;
  logic hit;
  logic forced;
  logic space;
  logic load;
  assign space = ~OUT_VALID | OUT_READY;
  assign load = space & hit;
  always_comb begin
    rr_gnt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) rr_gnt = IN_VALID[i] ? SEL_W'(i) : rr_gnt;
    for (int i = CHANNELS - 1; i >= 0; i--) rr_gnt = (IN_VALID[i] && i >= int'(ptr)) ? SEL_W'(i) : rr_gnt;
  end
`ifdef MUX_RR_FORCE_SEL_EN
  logic [2**SEL_W-1:0] valid_pad;
  assign valid_pad = (2**SEL_W)'(IN_VALID);
  assign forced = FORCE_EN;
  assign gnt = FORCE_EN ? FORCE_SEL : rr_gnt;
  assign hit = FORCE_EN ? valid_pad[FORCE_SEL] : |IN_VALID;
`else
  assign forced = 1'b0;
  assign gnt = rr_gnt;
  assign hit = |IN_VALID;
`endif
  always_comb begin
    din = '0;
    IN_READY = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      din = (gnt == SEL_W'(i)) ? IN_DATA[i*WIDTH +: WIDTH] : din;
      IN_READY[i] = load & ~RST & (gnt == SEL_W'(i));
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_DATA <= '0;
      OUT_SEL <= '0;
      ptr <= '0;
    end else if (load) begin
      OUT_VALID <= 1'b1;
      OUT_DATA <= din;
      OUT_SEL <= gnt;
      if (!forced) ptr <= (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: scoreboard bench for mux_rr_reg (8-channel and 5-channel instances)
module tb_mux_rr_reg;
  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [255:0] in_data = '0;
  logic [7:0] in_valid = '0;
  logic [7:0] in_ready;
  logic [31:0] out_data;
  logic [2:0] out_sel;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [159:0] d5 = '0;
  logic [4:0] v5 = '0;
  logic [4:0] rd5;
  logic [31:0] o5_data;
  logic [2:0] o5_sel;
  logic o5_valid;
  logic r5 = 1'b0;
  exp_t q[$];
  exp_t e;
  int passed = 0;
  int total = 0;
`ifdef MUX_RR_FORCE_SEL_EN
  logic force_en = 1'b0;
  logic [2:0] force_sel = '0;
  logic force5_en = 1'b0;
  logic [2:0] force5_sel = '0;
`endif
  always #5 clk = ~clk;
  mux_rr_reg #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
`ifdef MUX_RR_FORCE_SEL_EN
    .FORCE_EN(force_en), .FORCE_SEL(force_sel),
`endif
    .OUT_DATA(out_data), .OUT_SEL(out_sel), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );
  mux_rr_reg #(.WIDTH(32), .CHANNELS(5), .SEL_W(3)) dut5 (
    .CLK(clk), .RST(rst), .IN_DATA(d5), .IN_VALID(v5), .IN_READY(rd5),
`ifdef MUX_RR_FORCE_SEL_EN
    .FORCE_EN(force5_en), .FORCE_SEL(force5_sel),
`endif
    .OUT_DATA(o5_data), .OUT_SEL(o5_sel), .OUT_VALID(o5_valid), .OUT_READY(r5)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    in_valid = '0;
    v5 = '0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 8'h00) $display("FAIL rst_ready got %h exp 00", in_ready); else passed++;
    step();
    total++;
    if ({out_valid, out_sel, out_data} !== 36'h0) $display("FAIL rst_state got v=%b s=%0d d=%h exp 0", out_valid, out_sel, out_data); else passed++;
    rst = 1'b0;
    in_valid = 8'h08;
    in_data[3*32 +: 32] = 32'h00aadd00;
    #1;
    total++;
    if (in_ready !== 8'h08) $display("FAIL hold_ready got %h exp 08", in_ready); else passed++;
    step();
    in_valid = '0;
    step();
    total++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 3'd3, 32'h00aadd00}) $display("FAIL hold_word got v=%b s=%0d d=%h exp 1/3/00aadd00", out_valid, out_sel, out_data); else passed++;
    rst = 1'b1;
    in_valid = 8'h08;
    #1;
    total++;
    if (in_ready !== 8'h00) $display("FAIL midrst_ready got %h exp 00", in_ready); else passed++;
    step();
    total++;
    if ({out_valid, out_sel, out_data} !== 36'h0) $display("FAIL midrst_state got v=%b s=%0d d=%h exp 0", out_valid, out_sel, out_data); else passed++;
    rst = 1'b0;
    in_valid = '1;
    out_ready = 1'b1;
    q.push_back('{3'd0, in_data[31:0]});
    step();
    e = q.pop_front();
    total++;
    if (!out_valid || {out_sel, out_data} !== e) $display("FAIL rst_ptr got v=%b s=%0d exp s=%0d", out_valid, out_sel, e.sel); else passed++;
  endtask
  task automatic test_single;
    do_reset();
    in_data[2*32 +: 32] = 32'h9999ffdd;
    in_valid = 8'h04;
    out_ready = 1'b1;
    q.push_back('{3'd2, 32'h9999ffdd});
    #1;
    total++;
    if (in_ready !== 8'h04) $display("FAIL single_ready got %h exp 04", in_ready); else passed++;
    step();
    in_valid = '0;
    e = q.pop_front();
    total++;
    if (!out_valid || {out_sel, out_data} !== e) $display("FAIL single_out got v=%b s=%0d d=%h exp s=%0d d=%h", out_valid, out_sel, out_data, e.sel, e.data); else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_drain got %b exp 0", out_valid); else passed++;
    in_valid = '1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'h01010101 * i;
    q.push_back('{3'd3, 32'h03030303});
    step();
    e = q.pop_front();
    total++;
    if (!out_valid || {out_sel, out_data} !== e) $display("FAIL single_ptr got s=%0d d=%h exp s=%0d d=%h", out_sel, out_data, e.sel, e.data); else passed++;
    in_valid = '0;
  endtask
  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'h11111111 * i;
    in_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) q.push_back('{3'(k % 8), 32'h11111111 * (k % 8)});
    for (int k = 0; k < 9; k++) begin
      step();
      e = q.pop_front();
      total++;
      if (!out_valid || {out_sel, out_data} !== e) $display("FAIL rr_%0d got v=%b s=%0d d=%h exp s=%0d d=%h", k, out_valid, out_sel, out_data, e.sel, e.data); else passed++;
    end
    in_valid = '0;
  endtask
  task automatic test_backpressure;
    do_reset();
    in_data[4*32 +: 32] = 32'h44444444;
    in_data[5*32 +: 32] = 32'h55555555;
    in_valid = 8'h10;
    out_ready = 1'b1;
    step();
    in_valid = 8'h20;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 8'h00) $display("FAIL bp_ready_%0d got %h exp 00", k, in_ready); else passed++;
      step();
      total++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'd4, 32'h44444444}) $display("FAIL bp_hold_%0d got v=%b s=%0d d=%h exp 1/4/44444444", k, out_valid, out_sel, out_data); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 8'h20) $display("FAIL bp_release got %h exp 20", in_ready); else passed++;
    q.push_back('{3'd5, 32'h55555555});
    step();
    in_valid = '0;
    e = q.pop_front();
    total++;
    if (!out_valid || {out_sel, out_data} !== e) $display("FAIL bp_next got s=%0d d=%h exp s=%0d d=%h", out_sel, out_data, e.sel, e.data); else passed++;
    step();
    total++;
    if ({out_valid, out_sel, out_data} !== {1'b0, 3'd5, 32'h55555555}) $display("FAIL bp_drain got v=%b s=%0d d=%h exp 0/5/55555555", out_valid, out_sel, out_data); else passed++;
  endtask
  task automatic test_wrap5;
    do_reset();
    d5[0 +: 32] = 32'h0000000a;
    d5[3*32 +: 32] = 32'h00000033;
    d5[4*32 +: 32] = 32'h00000044;
    v5 = 5'b01000;
    r5 = 1'b1;
    step();
    total++;
    if ({o5_valid, o5_sel, o5_data} !== {1'b1, 3'd3, 32'h33}) $display("FAIL wrap_prime got v=%b s=%0d d=%h exp 1/3/33", o5_valid, o5_sel, o5_data); else passed++;
    v5 = 5'b10001;
    #1;
    total++;
    if (rd5 !== 5'b10000) $display("FAIL wrap_ready got %b exp 10000", rd5); else passed++;
    q.push_back('{3'd4, 32'h44});
    q.push_back('{3'd0, 32'h0a});
    q.push_back('{3'd4, 32'h44});
    for (int k = 0; k < 3; k++) begin
      step();
      e = q.pop_front();
      total++;
      if (!o5_valid || {o5_sel, o5_data} !== e) $display("FAIL wrap_%0d got v=%b s=%0d d=%h exp s=%0d d=%h", k, o5_valid, o5_sel, o5_data, e.sel, e.data); else passed++;
    end
    v5 = '0;
    r5 = 1'b0;
  endtask
`ifdef MUX_RR_FORCE_SEL_EN
  task automatic test_force;
    do_reset();
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'h11111111 * i;
    in_valid = '1;
    out_ready = 1'b1;
    force_en = 1'b1;
    force_sel = 3'd6;
    for (int k = 0; k < 3; k++) begin
      q.push_back('{3'd6, 32'h66666666});
      step();
      e = q.pop_front();
      total++;
      if (!out_valid || {out_sel, out_data} !== e) $display("FAIL force_%0d got s=%0d d=%h exp s=6", k, out_sel, out_data); else passed++;
    end
    in_valid = 8'hbf;
    #1;
    total++;
    if (in_ready !== 8'h00) $display("FAIL force_noready got %h exp 00", in_ready); else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL force_noload got %b exp 0", out_valid); else passed++;
    force_en = 1'b0;
    in_valid = '1;
    q.push_back('{3'd0, 32'h0});
    step();
    e = q.pop_front();
    total++;
    if (!out_valid || {out_sel, out_data} !== e) $display("FAIL force_ptr got s=%0d exp s=0", out_sel); else passed++;
    in_valid = '0;
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap5();
`ifdef MUX_RR_FORCE_SEL_EN
    test_force();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor to the 32-bit 8:1 datapath mux.
- Merges CHANNELS valid/ready input streams of WIDTH bits into one registered output stream.
- Selection is made by a round-robin arbiter instead of an external select code.
- Sits between the register file / ALU result sources and any shared sink (write-back bus, memory write port) that needs fair multi-source access with backpressure.

Parameters:
- WIDTH, 32 (`DATA_INDEX_LIMIT+1): data bits per channel.
- CHANNELS, 8: number of input channels, 2..16; need not be a power of 2.
- SEL_W, 3: index width, must satisfy 2^SEL_W >= CHANNELS.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- IN_DATA  input  CHANNELS*WIDTH  flat bus; channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- IN_VALID  input  CHANNELS  per-channel valid.
- IN_READY  output  CHANNELS  per-channel ready; combinational.
- OUT_DATA  output  WIDTH  registered selected word.
- OUT_SEL  output  SEL_W  registered index of the channel that supplied OUT_DATA.
- OUT_VALID  output  1  registered output valid.
- OUT_READY  input  1  sink ready.

Behaviour:
- Reset (RST=1 at a CLK edge): OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, round-robin pointer PTR=0.
  - Reset mid-operation discards any held word.
  - IN_READY is all zero while RST=1.
- State: output register (EMPTY when OUT_VALID=0, FULL when OUT_VALID=1) plus PTR (SEL_W bits, range 0..CHANNELS-1).
- Space available: SPACE = ~OUT_VALID | OUT_READY.
- Grant (combinational): G = first i with IN_VALID[i]=1, searching from PTR upward and wrapping CHANNELS-1 -> 0. No grant when IN_VALID=0.
- IN_READY[i] = SPACE & (i==G) & ~RST. At most one bit is high at a time.
- LOAD = SPACE & any IN_VALID.
- On LOAD:
  - OUT_DATA <= IN_DATA[G], OUT_SEL <= G, OUT_VALID <= 1.
  - PTR <= G+1, or 0 when G=CHANNELS-1.
- When OUT_VALID & OUT_READY & ~LOAD: OUT_VALID <= 0. OUT_DATA and OUT_SEL keep their values.
- When FULL & ~OUT_READY: all outputs and PTR hold; IN_READY=0. A source must hold IN_DATA and IN_VALID until its ready is seen.
- Latency: 1 cycle from an accepted input to OUT_VALID.
- Throughput: 1 word/cycle when OUT_READY stays high (simultaneous drain and load in the same cycle).
- Fairness: with all channels continuously valid, grants cycle 0,1,...,CHANNELS-1,0,... Each requester waits at most CHANNELS-1 grants.
- PTR changes only on LOAD. Idle cycles do not advance it.
- Channels whose index is >= CHANNELS are never granted. OUT_SEL never exceeds CHANNELS-1.

Optional Feature:
- Macro: MUX_RR_FORCE_SEL_EN.
- Defined:
  - Adds ports FORCE_EN (input, 1) and FORCE_SEL (input, SEL_W).
  - When FORCE_EN=1, G = FORCE_SEL if IN_VALID[FORCE_SEL]=1; otherwise there is no grant.
  - Forced loads do not modify PTR.
  - FORCE_SEL >= CHANNELS gives no grant.
- Undefined: the ports are absent and pure round-robin is always used.

Test Plan:
- Reset mid-hold: load channel 3 with 'h00aadd00, hold OUT_READY=0, assert RST one cycle -> OUT_VALID=0, OUT_DATA=0, PTR=0, IN_READY=0 during RST.
- Single requester: only IN_VALID[2]=1 with 'h9999ffdd, OUT_READY=1 -> next cycle OUT_DATA='h9999ffdd, OUT_SEL=2, OUT_VALID=1, PTR=3; following cycle OUT_VALID=0.
- All valid, channel i = 'h11111111*i, OUT_READY=1 -> OUT_SEL 0,1,...,7,0 on consecutive cycles with matching data, no bubbles.
- Backpressure: FULL with 'h44444444 from ch4, OUT_READY=0 for 3 cycles, ch5='h55555555 valid -> OUT_DATA stable, IN_READY=0; first cycle with OUT_READY=1 -> next cycle OUT_DATA='h55555555, OUT_SEL=5.
- Wrap / non-power-of-2: CHANNELS=5, PTR=4, IN_VALID=5'b10001 -> grant 4, then 0; PTR returns to 0 after grant 4.
- MUX_RR_FORCE_SEL_EN: all valid, FORCE_EN=1, FORCE_SEL=6 for 3 loads -> OUT_SEL=6 three times, PTR unchanged; then FORCE_SEL=6 with IN_VALID[6]=0 -> no load.
